// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the serial ALU front end: opcode constants,
// FSM state encoding and the opcode validity check.
package alu_uart_interface_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_uart_interface_timeout_counter.sv
// Inter-byte idle counter: counts while enabled, pulses tc on the cycle
// the count sits at TIMEOUT-1, and restarts from zero on clear.
module alu_uart_interface_timeout_counter #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;
    logic          w_at_tc;

    assign w_at_tc = (r_count == TC_VAL);
    assign tc      = enable && w_at_tc;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_at_tc ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_uart_interface.sv
// Collects A, B and opcode bytes from the UART receiver, drives the ALU,
// then hands the ALU result to the UART transmitter as a single byte.
module alu_uart_interface
    import alu_uart_interface_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 1000000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NB_DATA-1:0] RX_DATA,
    input  logic               RX_DONE,
    input  logic               TX_DONE,
    input  logic [NB_DATA-1:0] ALU_RESULT,
    output logic [NB_DATA-1:0] ALU_A,
    output logic [NB_DATA-1:0] ALU_B,
    output logic [NB_OP-1:0]   ALU_OP,
    output logic [NB_DATA-1:0] TX_DATA,
    output logic               TX_START,
    output logic               ERR,
    output logic               BUSY
);

    state_t             r_state;
    state_t             w_state_next;
    logic [NB_DATA-1:0] r_alu_a, w_alu_a_next;
    logic [NB_DATA-1:0] r_alu_b, w_alu_b_next;
    logic [NB_OP-1:0]   r_alu_op, w_alu_op_next;
    logic [NB_DATA-1:0] r_tx_data, w_tx_data_next;
    logic               r_tx_start, w_tx_start_next;
    logic               r_err, w_err_next;

    logic w_hi_clear;
    logic w_op_ok;
    logic w_cnt_en;
    logic w_cnt_clear;
    logic w_timeout;

    // A byte wider than the opcode field is only legal with its upper bits clear
    generate
        if (NB_DATA > NB_OP) begin : g_hi_bits
            assign w_hi_clear = ~|RX_DATA[NB_DATA-1:NB_OP];
        end else begin : g_no_hi_bits
            assign w_hi_clear = 1'b1;
        end
    endgenerate

    assign w_op_ok = w_hi_clear && is_valid_op(RX_DATA[NB_OP-1:0]);

    assign w_cnt_en    = (r_state == WAIT_B) || (r_state == WAIT_OP);
    assign w_cnt_clear = !w_cnt_en || RX_DONE;

    alu_uart_interface_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (CLK),
        .srst   (RESET),
        .clear  (w_cnt_clear),
        .enable (w_cnt_en),
        .tc     (w_timeout)
    );

    always_comb begin
        w_state_next    = r_state;
        w_alu_a_next    = r_alu_a;
        w_alu_b_next    = r_alu_b;
        w_alu_op_next   = r_alu_op;
        w_tx_data_next  = r_tx_data;
        w_tx_start_next = 1'b0;
        w_err_next      = 1'b0;
        case (r_state)
            WAIT_A: begin
                if (RX_DONE) begin
                    w_alu_a_next = RX_DATA;
                    w_state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                // A byte arriving on the expiry cycle still wins over the timeout
                if (RX_DONE) begin
                    w_alu_b_next = RX_DATA;
                    w_state_next = WAIT_OP;
                end else if (w_timeout) begin
                    w_err_next   = 1'b1;
                    w_state_next = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (RX_DONE) begin
                    if (w_op_ok) begin
                        w_alu_op_next = RX_DATA[NB_OP-1:0];
                        w_state_next  = EXEC;
                    end else begin
                        w_err_next    = 1'b1;
                        w_state_next  = WAIT_A;
                    end
                end else if (w_timeout) begin
                    w_err_next   = 1'b1;
                    w_state_next = WAIT_A;
                end
            end
            EXEC: begin
                w_tx_data_next  = ALU_RESULT;
                w_tx_start_next = 1'b1;
                w_state_next    = WAIT_TX;
            end
            WAIT_TX: begin
                if (TX_DONE) begin
                    w_state_next = WAIT_A;
                end
            end
            default: begin
                w_state_next = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= WAIT_A;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_alu_a    <= w_alu_a_next;
            r_alu_b    <= w_alu_b_next;
            r_alu_op   <= w_alu_op_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_start <= w_tx_start_next;
            r_err      <= w_err_next;
        end
    end

    assign ALU_A    = r_alu_a;
    assign ALU_B    = r_alu_b;
    assign ALU_OP   = r_alu_op;
    assign TX_DATA  = r_tx_data;
    assign TX_START = r_tx_start;
    assign ERR      = r_err;
    assign BUSY     = (r_state != WAIT_A);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Scoreboarded bench for alu_uart_interface with a behavioural ALU stand-in.
module tb_alu_uart_interface;
    import alu_uart_interface_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] RX_DATA = 8'h00;
    logic       RX_DONE = 1'b0;
    logic       TX_DONE = 1'b0;
    logic [7:0] ALU_RESULT;
    logic [7:0] ALU_A, ALU_B, TX_DATA;
    logic [5:0] ALU_OP;
    logic       TX_START, ERR, BUSY;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];

    alu_uart_interface #(.NB_DATA(8), .NB_OP(6), .TIMEOUT(16)) dut (
        .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_DONE(RX_DONE),
        .TX_DONE(TX_DONE), .ALU_RESULT(ALU_RESULT), .ALU_A(ALU_A),
        .ALU_B(ALU_B), .ALU_OP(ALU_OP), .TX_DATA(TX_DATA),
        .TX_START(TX_START), .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return 8'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb ALU_RESULT = is_valid_op(ALU_OP) ? alu_model(ALU_A, ALU_B, ALU_OP) : 8'h00;

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA = b;
        RX_DONE = 1'b1;
        @(negedge CLK);
        RX_DONE = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge CLK);
        TX_DONE = 1'b1;
        @(negedge CLK);
        TX_DONE = 1'b0;
    endtask

    task automatic wait_tx_start(output int n);
        n = 0;
        while (!TX_START && n < 20) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        tests++;
        if ({ALU_A, ALU_B, ALU_OP, TX_DATA} !== 30'h0) begin
            fails++;
            $display("FAIL reset_regs: got A=%h B=%h OP=%h TX=%h, want all 0", ALU_A, ALU_B, ALU_OP, TX_DATA);
        end
        tests++;
        if ({TX_START, ERR, BUSY} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got start/err/busy=%b, want 000", {TX_START, ERR, BUSY});
        end
        RESET = 1'b0;
    endtask

    task automatic test_add();
        int n;
        send_byte(8'h0B);
        tests++;
        if (ALU_A !== 8'h0B || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL add_opa: got A=%h busy=%b, want 0b 1", ALU_A, BUSY);
        end
        send_byte(8'h01);
        tests++;
        if (ALU_B !== 8'h01) begin
            fails++;
            $display("FAIL add_opb: got %h, want 01", ALU_B);
        end
        exp_q.push_back(8'h0C);
        send_byte(8'h20);
        tests++;
        if (ALU_OP !== 6'h20) begin
            fails++;
            $display("FAIL add_op: got %h, want 20", ALU_OP);
        end
        wait_tx_start(n);
        tests++;
        if (n !== 1) begin
            fails++;
            $display("FAIL add_latency: got %0d cycles after opcode edge, want 1", n);
        end
        if (TX_START && exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            tests++;
            if (TX_DATA !== e) begin
                fails++;
                $display("FAIL add_txdata: got %h, want %h", TX_DATA, e);
            end
        end
        @(negedge CLK);
        tests++;
        if (TX_START !== 1'b0 || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL add_pulse: got start=%b busy=%b, want 0 1", TX_START, BUSY);
        end
        repeat (4) @(negedge CLK);
        tests++;
        if (BUSY !== 1'b1) begin
            fails++;
            $display("FAIL add_busy_hold: got %b, want 1", BUSY);
        end
        pulse_tx_done();
        tests++;
        if (BUSY !== 1'b0) begin
            fails++;
            $display("FAIL add_idle: got busy=%b, want 0", BUSY);
        end
        $display("[TB] frame 0b 01 20 -> tx %h", TX_DATA);
    endtask

    task automatic test_all_ops();
        logic [7:0] ops  [7] = '{8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
        logic [7:0] exps [7] = '{8'h0A, 8'h01, 8'h0B, 8'h0A, 8'hF4, 8'h05, 8'h05};
        int n;
        for (int i = 0; i < 7; i++) begin
            send_byte(8'h0B);
            send_byte(8'h01);
            exp_q.push_back(exps[i]);
            send_byte(ops[i]);
            wait_tx_start(n);
            tests++;
            if (n !== 1) begin
                fails++;
                $display("FAIL op_%h_latency: got %0d, want 1", ops[i], n);
            end
            if (TX_START && exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                tests++;
                if (TX_DATA !== e) begin
                    fails++;
                    $display("FAIL op_%h_txdata: got %h, want %h", ops[i], TX_DATA, e);
                end
            end
            $display("[TB] frame 0b 01 %h -> tx %h", ops[i], TX_DATA);
            pulse_tx_done();
        end
        exp_q.delete();
    endtask

    task automatic test_invalid_op();
        logic [7:0] bad [2] = '{8'h3F, 8'h60};
        int starts;
        int n;
        for (int i = 0; i < 2; i++) begin
            send_byte(8'h0B);
            send_byte(8'h01);
            send_byte(bad[i]);
            tests++;
            if (ERR !== 1'b1 || BUSY !== 1'b0) begin
                fails++;
                $display("FAIL badop_%h_err: got err=%b busy=%b, want 1 0", bad[i], ERR, BUSY);
            end
            starts = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge CLK);
                if (TX_START) starts++;
            end
            tests++;
            if (ERR !== 1'b0 || starts !== 0 || ALU_OP !== 6'h02) begin
                fails++;
                $display("FAIL badop_%h_after: got err=%b starts=%0d op=%h, want 0 0 02", bad[i], ERR, starts, ALU_OP);
            end
            $display("[TB] frame 0b 01 %h -> err", bad[i]);
        end
        send_byte(8'h02);
        send_byte(8'h03);
        exp_q.push_back(8'h05);
        send_byte(8'h20);
        wait_tx_start(n);
        tests++;
        if (!TX_START || exp_q.size() == 0 || TX_DATA !== exp_q[0]) begin
            fails++;
            $display("FAIL badop_recover: got start=%b tx=%h, want 1 05", TX_START, TX_DATA);
        end
        exp_q.delete();
        $display("[TB] frame 02 03 20 -> tx %h", TX_DATA);
        pulse_tx_done();
    endtask

    task automatic test_timeout();
        int k;
        int n;
        logic busy_before;
        send_byte(8'h0B);
        k = 0;
        busy_before = 1'b0;
        while (!ERR && k < 40) begin
            busy_before = BUSY;
            @(negedge CLK);
            k++;
        end
        tests++;
        if (k !== 16 || BUSY !== 1'b0 || busy_before !== 1'b1) begin
            fails++;
            $display("FAIL timeout_fire: got %0d cycles busy=%b, want 16 0", k, BUSY);
        end
        $display("[TB] byte 0b then idle -> err after %0d cycles", k);
        // Byte arriving on the expiry cycle is accepted and the timeout is suppressed
        send_byte(8'h0C);
        repeat (14) @(negedge CLK);
        send_byte(8'h04);
        tests++;
        if (ERR !== 1'b0 || BUSY !== 1'b1 || ALU_B !== 8'h04) begin
            fails++;
            $display("FAIL timeout_race: got err=%b busy=%b B=%h, want 0 1 04", ERR, BUSY, ALU_B);
        end
        exp_q.push_back(8'h10);
        send_byte(8'h20);
        wait_tx_start(n);
        if (TX_START && exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            tests++;
            if (TX_DATA !== e) begin
                fails++;
                $display("FAIL timeout_newframe: got %h, want %h", TX_DATA, e);
            end
        end else begin
            tests++;
            fails++;
            $display("FAIL timeout_newframe: got no TX_START, want tx 10");
        end
        $display("[TB] frame 0c 04 20 at expiry edge -> tx %h", TX_DATA);
        pulse_tx_done();
    endtask

    task automatic test_ignore_during_tx();
        int n;
        send_byte(8'h0B);
        send_byte(8'h01);
        exp_q.push_back(8'h0C);
        send_byte(8'h20);
        wait_tx_start(n);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        send_byte(8'h55);
        send_byte(8'h66);
        tests++;
        if (TX_DATA !== 8'h0C || BUSY !== 1'b1 || ALU_A !== 8'h0B || TX_START !== 1'b0) begin
            fails++;
            $display("FAIL ignore_rx: got tx=%h busy=%b A=%h start=%b, want 0c 1 0b 0", TX_DATA, BUSY, ALU_A, TX_START);
        end
        @(negedge CLK);
        RX_DATA = 8'h77;
        RX_DONE = 1'b1;
        TX_DONE = 1'b1;
        @(negedge CLK);
        RX_DONE = 1'b0;
        TX_DONE = 1'b0;
        tests++;
        if (BUSY !== 1'b0 || ALU_A !== 8'h0B) begin
            fails++;
            $display("FAIL txdone_rx_same: got busy=%b A=%h, want 0 0b", BUSY, ALU_A);
        end
        send_byte(8'h10);
        send_byte(8'h20);
        exp_q.push_back(8'h30);
        send_byte(8'h20);
        wait_tx_start(n);
        tests++;
        if (!TX_START || exp_q.size() == 0 || TX_DATA !== exp_q[0]) begin
            fails++;
            $display("FAIL ignore_nextframe: got start=%b tx=%h, want 1 30", TX_START, TX_DATA);
        end
        exp_q.delete();
        $display("[TB] frame 10 20 20 after dropped bytes -> tx %h", TX_DATA);
        pulse_tx_done();
    endtask

    task automatic test_reset_mid();
        int n;
        send_byte(8'h0B);
        send_byte(8'h01);
        pulse_reset();
        tests++;
        if ({ALU_A, ALU_B, ALU_OP, TX_DATA, TX_START, ERR, BUSY} !== 33'h0) begin
            fails++;
            $display("FAIL reset_waitop: got A=%h B=%h busy=%b, want all 0", ALU_A, ALU_B, BUSY);
        end
        RESET = 1'b0;
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h26);
        wait_tx_start(n);
        tests++;
        if (TX_START !== 1'b1 || TX_DATA !== 8'h01) begin
            fails++;
            $display("FAIL reset_prep: got start=%b tx=%h, want 1 01", TX_START, TX_DATA);
        end
        pulse_reset();
        tests++;
        if ({ALU_A, ALU_B, ALU_OP, TX_DATA, TX_START, ERR, BUSY} !== 33'h0) begin
            fails++;
            $display("FAIL reset_waittx: got tx=%h start=%b busy=%b, want all 0", TX_DATA, TX_START, BUSY);
        end
        RESET = 1'b0;
        pulse_tx_done();
        @(negedge CLK);
        tests++;
        if (BUSY !== 1'b0 || TX_START !== 1'b0 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL late_txdone: got busy=%b start=%b err=%b, want 0 0 0", BUSY, TX_START, ERR);
        end
        send_byte(8'h80);
        send_byte(8'h01);
        exp_q.push_back(8'hC0);
        send_byte(8'h03);
        wait_tx_start(n);
        tests++;
        if (!TX_START || exp_q.size() == 0 || TX_DATA !== exp_q[0]) begin
            fails++;
            $display("FAIL reset_recover: got start=%b tx=%h, want 1 c0", TX_START, TX_DATA);
        end
        exp_q.delete();
        $display("[TB] frame 80 01 03 after resets -> tx %h", TX_DATA);
        pulse_tx_done();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_all_ops();
        test_invalid_op();
        test_timeout();
        test_ignore_during_tx();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
